// File: rtl/lutram_mig_pkg.sv
// Shared definitions for the LUTRAM save/restore engine: the state encoding
// used by the controller.
package lutram_mig_pkg;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_SAVE_ENC    = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC   = 2'd2;
  localparam logic [1:0] ST_RESTORE_ENC = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE_ENC,
    SAVE    = ST_SAVE_ENC,
    DRAIN   = ST_DRAIN_ENC,
    RESTORE = ST_RESTORE_ENC
  } mig_state_e;

endpackage

// File: rtl/lutram_w.sv
// Simple dual-port LUTRAM: synchronous write, registered read address,
// combinational read data.
module lutram_w #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] r_addr_q;

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
    r_addr_q <= r_addr;
  end

  assign r_data = mem[r_addr_q];

endmodule

// File: rtl/mig_skid_fifo.sv
// Two-entry FIFO with valid/ready on both sides; absorbs the RAM read latency
// so the save stream can stall without losing or repeating words.
module mig_skid_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  push;
  logic                  pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/lutram_migrator.sv
// Save/restore engine in front of a lutram_w: user passthrough when idle,
// otherwise streams the whole RAM out (save) or refills it from a stream (restore).
module lutram_migrator
  import lutram_mig_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  save_start,
  input  logic                  restore_start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  usr_we,
  input  logic [ADDR_WIDTH-1:0] usr_w_addr,
  input  logic [DATA_WIDTH-1:0] usr_w_data,
  input  logic [ADDR_WIDTH-1:0] usr_r_addr,
  output logic [DATA_WIDTH-1:0] usr_r_data,
  output logic                  usr_stall,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

  mig_state_e            state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  in_flight;
  logic                  in_flight_last;
  logic [1:0]            fifo_count;
  logic                  fifo_in_ready;
  logic [DATA_WIDTH:0]   fifo_out;
  logic                  fifo_pop;
  logic                  issue;
  logic                  s_accept;

  assign busy       = (state != IDLE);
  assign usr_stall  = busy;
  assign s_ready    = (state == RESTORE);
  assign s_accept   = s_valid && s_ready;
  assign usr_r_data = ram_r_data;
  assign fifo_pop   = m_valid && m_ready;
  assign m_data     = fifo_out[DATA_WIDTH-1:0];
  assign m_last     = m_valid && fifo_out[DATA_WIDTH];

  // A beat leaving the FIFO this cycle frees its slot, keeping the stream bubble-free.
  assign issue = (state == SAVE) &&
                 ((3'(fifo_count) + 3'(in_flight) - 3'(fifo_pop)) < 3'd2);

  always_comb begin
    ram_we     = 1'b0;
    ram_w_addr = wr_addr;
    ram_w_data = s_data;
    ram_r_addr = rd_addr;
    if (state == IDLE) begin
      ram_we     = usr_we;
      ram_w_addr = usr_w_addr;
      ram_w_data = usr_w_data;
      ram_r_addr = usr_r_addr;
    end else begin
      ram_we = s_accept;
    end
  end

  mig_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_flight && fifo_in_ready),
    .in_ready (fifo_in_ready),
    .in_data  ({in_flight_last, ram_r_data}),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (fifo_out),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rd_addr        <= '0;
      wr_addr        <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done           <= 1'b0;
      in_flight      <= issue;
      in_flight_last <= issue && (rd_addr == LAST_ADDR);
      case (state)
        IDLE: begin
          if (save_start) begin
            state   <= SAVE;
            rd_addr <= '0;
            err     <= 1'b0;
          end else if (restore_start) begin
            state   <= RESTORE;
            wr_addr <= '0;
            err     <= 1'b0;
          end
        end
        SAVE: begin
          if (issue) begin
            if (rd_addr == LAST_ADDR) state <= DRAIN;
            else rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Finish on the cycle the final beat leaves, so done follows it directly.
          if (!in_flight &&
              (fifo_count == 2'd0 || (fifo_count == 2'd1 && fifo_pop))) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        RESTORE: begin
          if (s_accept) begin
            if (s_last != (wr_addr == LAST_ADDR)) err <= 1'b1;
            if (wr_addr == LAST_ADDR) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lutram_migrator.sv
// Directed bench for lutram_migrator driving a real lutram_w: passthrough,
// save (steady and stalled), restore (clean and misframed), reset mid-save.
module tb_lutram_migrator;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int WORDS = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          save_start = 1'b0, restore_start = 1'b0;
  logic          busy, done, err;
  logic          usr_we = 1'b0;
  logic [AW-1:0] usr_w_addr = '0, usr_r_addr = '0;
  logic [DW-1:0] usr_w_data = '0, usr_r_data;
  logic          usr_stall;
  logic          ram_we;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_w_data, ram_r_data;
  logic          m_valid, m_last, m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;

  int num_checks = 0;
  int num_errors = 0;

  always #5 clk = ~clk;

  lutram_migrator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .save_start(save_start), .restore_start(restore_start),
    .busy(busy), .done(done), .err(err),
    .usr_we(usr_we), .usr_w_addr(usr_w_addr), .usr_w_data(usr_w_data),
    .usr_r_addr(usr_r_addr), .usr_r_data(usr_r_data), .usr_stall(usr_stall),
    .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready)
  );

  lutram_w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
    .clk(clk), .we(ram_we), .w_addr(ram_w_addr), .w_data(ram_w_data),
    .r_addr(ram_r_addr), .r_data(ram_r_data)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses the command inputs for one cycle; returns at the negedge after the command edge.
  task automatic applyStimulus(input logic do_save, input logic do_restore);
    @(negedge clk);
    save_start    = do_save;
    restore_start = do_restore;
    @(negedge clk);
    save_start    = 1'b0;
    restore_start = 1'b0;
  endtask

  task automatic preloadRam();
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      usr_we     = 1'b1;
      usr_w_addr = AW'(i);
      usr_w_data = DW'(i);
    end
    @(negedge clk);
    usr_we = 1'b0;
  endtask

  task automatic runSave(input bit rand_ready, input logic both_cmds);
    int idx = 0, cyc = 0, first_at = -1, last_at = -1, done_at = -1;
    int done_cnt = 0, bad = 0, max_cnt = 0;
    applyStimulus(1'b1, both_cmds);
    while (cyc < WORDS * 8 + 50 && !(done_at >= 0 && cyc > done_at + 2)) begin
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) begin
        checkOutput("save_busy", busy, 1);
        checkOutput("save_no_s_ready", s_ready, 0);
      end
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (m_valid && m_ready) begin
        if (first_at < 0) first_at = cyc;
        if (m_data !== DW'(idx) || m_last !== (idx == WORDS - 1)) bad++;
        if (idx == WORDS - 1) last_at = cyc;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    checkOutput("save_beats", idx, WORDS);
    checkOutput("save_bad_beats", bad, 0);
    checkOutput("save_done_pulses", done_cnt, 1);
    checkOutput("save_done_after_last", done_at, last_at + 1);
    checkOutput("save_fifo_le2", max_cnt <= 2, 1);
    checkOutput("save_idle_after", busy, 0);
    if (!rand_ready) begin
      checkOutput("save_first_latency", first_at, 2);
      checkOutput("save_no_bubbles", last_at - first_at, WORDS - 1);
    end
  endtask

  task automatic runRestore(input logic [DW-1:0] key, input int last_beat, input logic exp_err);
    int i = 0, cyc = 0, done_at = -1, acc_at = -1, done_cnt = 0, bad_we = 0;
    applyStimulus(1'b0, 1'b1);
    while (cyc < WORDS * 8 + 50 && !(done_at >= 0 && cyc > done_at + 2)) begin
      if (i < WORDS) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = ~DW'(i) ^ key;
        s_last  = (i == last_beat);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      #1;
      if (cyc == 0) checkOutput("restore_ready_rise", s_ready, 1);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (s_valid && s_ready) begin
        if (ram_we !== 1'b1 || ram_w_addr !== AW'(i) || ram_w_data !== s_data) bad_we++;
        if (i == WORDS - 1) acc_at = cyc;
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checkOutput("restore_beats", i, WORDS);
    checkOutput("restore_write_port", bad_we, 0);
    checkOutput("restore_done_pulses", done_cnt, 1);
    checkOutput("restore_done_after_last", done_at, acc_at + 1);
    checkOutput("restore_err", err, exp_err);
    checkOutput("restore_ready_low_after", s_ready, 0);
  endtask

  task automatic readBack(input logic [DW-1:0] key, input string tag);
    int bad = 0;
    for (int a = 0; a < WORDS; a++) begin
      @(negedge clk);
      usr_r_addr = AW'(a);
      @(negedge clk);
      #1;
      if (usr_r_data !== (~DW'(a) ^ key)) bad++;
    end
    checkOutput(tag, bad, 0);
  endtask

  task automatic resetMidSave();
    int idx = 0, cyc = 0;
    applyStimulus(1'b1, 1'b0);
    while (idx <= 100 && cyc < WORDS * 4) begin
      m_ready = 1'b1;
      #1;
      if (m_valid && m_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("midsave_reached_100", idx, 101);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_m_last", m_last, 0);
    checkOutput("midrst_s_ready", s_ready, 0);
    checkOutput("midrst_stall", usr_stall, 0);
    checkOutput("midrst_fifo_empty", dut.u_fifo.count, 0);
    m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_stall", usr_stall, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Passthrough write then registered read
    @(negedge clk);
    usr_we = 1'b1; usr_w_addr = AW'(7); usr_w_data = 32'hA5;
    @(negedge clk);
    usr_we = 1'b0; usr_r_addr = AW'(7);
    #1;
    checkOutput("pass_r_addr", ram_r_addr, 7);
    @(negedge clk);
    #1;
    checkOutput("pass_r_data", usr_r_data, 32'hA5);

    preloadRam();
    $display("[TB] save with m_ready held high");
    runSave(1'b0, 1'b0);
    $display("[TB] save with random m_ready, both commands together");
    runSave(1'b1, 1'b1);
    $display("[TB] reset in the middle of a save");
    resetMidSave();
    runSave(1'b0, 1'b0);
    $display("[TB] clean restore");
    runRestore(32'h0, WORDS - 1, 1'b0);
    readBack(32'h0, "restore_readback");
    $display("[TB] misframed restore");
    runRestore(32'h0000_F0F0, 5, 1'b1);
    readBack(32'h0000_F0F0, "bad_restore_readback");

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/lutram_migrator.md
# lutram_migrator

Save/restore engine placed directly in front of one `lutram_w` instance (simple dual-port, registered read address, combinational read data). In IDLE it passes the user's read/write port through to the RAM unchanged. On command it takes over both RAM ports and either streams all WORDS entries out on a valid/ready stream (save) or refills them from an incoming stream (restore), so RAM state can be migrated between FPGAs.

## Interface
- ADDR_WIDTH, 12, RAM address width; must satisfy 2^ADDR_WIDTH >= WORDS
- DATA_WIDTH, 32, RAM word width
- WORDS, 4096, number of RAM entries transferred per save/restore
- clk  in  1  single clock, shared with the RAM
- rst  in  1  asynchronous, active-high reset
- save_start / restore_start  in  1 / 1  single-cycle command pulses
- busy  out  1  high in SAVE, DRAIN or RESTORE
- done  out  1  one-cycle pulse when an operation completes
- err  out  1  sticky restore framing error; cleared by the next accepted command
- usr_we, usr_w_addr, usr_w_data, usr_r_addr  in  1/ADDR_WIDTH/DATA_WIDTH/ADDR_WIDTH  user RAM port
- usr_r_data  out  DATA_WIDTH  equals ram_r_data
- usr_stall  out  1  equals busy; user accesses are ignored while high
- ram_we, ram_w_addr, ram_w_data, ram_r_addr  out  1/ADDR_WIDTH/DATA_WIDTH/ADDR_WIDTH  to the RAM
- ram_r_data  in  DATA_WIDTH  from the RAM, valid the cycle after ram_r_addr is sampled
- m_valid, m_data, m_last  out  1/DATA_WIDTH/1  save stream; m_ready  in  1
- s_valid, s_data, s_last  in  1/DATA_WIDTH/1  restore stream; s_ready  out  1

## Operation
- States: IDLE, SAVE, DRAIN, RESTORE. Reset puts the block in IDLE. In IDLE, ram_* = usr_* (combinational mux).
- Commands are honoured only in IDLE. If both commands are asserted in the same cycle, save takes precedence. Commands arriving while busy are dropped.
- SAVE: the read counter rd_addr starts at 0.
  - ram_r_addr = rd_addr. ram_we = 0.
  - An address is issued (rd_addr increments) when (buffer count + in-flight) < 2.
  - An in-flight flag marks that data will be captured into a 2-entry output FIFO on the next edge.
  - After address WORDS-1 is issued, the state moves to DRAIN.
- DRAIN: wait until the FIFO is empty and nothing is in flight, then pulse done and return to IDLE.
- m_last accompanies the word read from address WORDS-1. A beat transfers when m_valid && m_ready.
- RESTORE: s_ready = 1 and the write counter wr_addr starts at 0.
  - Each accepted beat drives ram_we = 1, ram_w_addr = wr_addr, ram_w_data = s_data (combinational), then increments wr_addr.
  - The operation ends on the beat with wr_addr = WORDS-1. That beat pulses done and returns the block to IDLE.
  - If s_last differs from (wr_addr == WORDS-1) on any accepted beat, set err. The transfer still ends on address count, never on s_last.
- Counters are ADDR_WIDTH bits wide. They never wrap inside an operation and are reset to 0 at each command.

## Timing
- Reset values: busy=0, done=0, err=0, m_valid=0, m_last=0, s_ready=0, FIFO empty, counters 0, no read in flight.
- Reset mid-operation aborts immediately: no done pulse, FIFO is flushed, RAM contents are left as partially written.
- Save latency: command accepted at edge E0; address 0 is presented after E0; data captured at E2; m_valid high after E2.
- Save throughput: 1 word/cycle while m_ready is held high, with zero bubbles after the first word.
- With m_ready low, at most 2 words are buffered and no address is issued. Data is never lost or duplicated.
- Restore latency: s_ready rises the cycle after the command edge. Each write lands in the RAM at the edge of acceptance.
- done is registered: it pulses in the cycle after the last m beat transfers (save) or after the last s beat is accepted (restore).
- WORDS=1: save emits one beat with m_last=1; restore completes on its first beat.

## Structure
- Shared package `lutram_mig_pkg` holds the state encoding localparams (IDLE=0, SAVE=1, DRAIN=2, RESTORE=3).
- The 2-entry output FIFO is a natural sub-module, `mig_skid_fifo`, parameterised by DATA_WIDTH, with valid/ready on both sides.
- The bench instantiates `lutram_migrator` connected to a real `lutram_w`.

## Test plan
- Passthrough: in IDLE, usr writes 0xA5 to address 7, then a read of address 7 -> usr_r_data = 0xA5 one cycle after the address.
- Save, m_ready always 1: preload ram[i] = i -> m_data 0..WORDS-1 on consecutive cycles, m_last only on the final beat, done 1 cycle later.
- Save with random m_ready (~50%) -> identical ordered sequence with no gaps or duplicates, and FIFO count never exceeds 2.
- Restore with s_data = ~i and correct s_last -> RAM readback equals ~i, err = 0, done pulses once.
- Restore with s_last asserted on beat 5 -> err = 1, all WORDS beats still written, done pulses after beat WORDS-1.
- rst asserted mid-SAVE at word 100 -> all outputs at reset values immediately, and the next save restarts from address 0.
